// File: rtl/beam_trigger_scaler.sv
// Per-beam trigger-rate scalers: edge-count every trigger bit over a fixed period,
// snapshot the counts on the terminal cycle and serve them through a 1-cycle readout port.
module beam_trigger_scaler #(
  parameter int unsigned NBEAMS        = 48,
  parameter int unsigned SCAL_BITS     = 16,
  parameter int unsigned PERIOD_CYCLES = 250000
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [2*NBEAMS-1:0]             trig_i,
  input  logic                            count_en_i,
  input  logic                            rd_en_i,
  input  logic [$clog2(2*NBEAMS)-1:0]     rd_addr_i,
  output logic [SCAL_BITS:0]              rd_data_o,
  output logic                            rd_valid_o,
  output logic                            period_o,
  output logic [15:0]                     period_cnt_o
);

  localparam int unsigned NSCAL = 2 * NBEAMS;
  localparam int unsigned DW    = SCAL_BITS + 1;
  localparam int unsigned TW    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [SCAL_BITS-1:0] CNT_MAX = {SCAL_BITS{1'b1}};

  logic [1:0]           rst_sync;
  logic                 rst_int_n;
  logic [TW-1:0]        timer;
  logic                 terminal_c;
  logic [NSCAL-1:0]     trig_q;
  logic [NSCAL-1:0]     event_c;
  logic [SCAL_BITS-1:0] cnt      [NSCAL];
  logic [SCAL_BITS-1:0] cnt_nxt  [NSCAL];
  logic [NSCAL-1:0]     sat;
  logic [NSCAL-1:0]     sat_nxt;
  logic [DW-1:0]        snap     [NSCAL];

  // Asynchronous assert, synchronous release of the internal reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n  = rst_sync[1];
  assign terminal_c = (timer == TW'(PERIOD_CYCLES - 1));
  assign event_c    = trig_i & ~trig_q;

  // Period timer and edge history run regardless of count_en_i
  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      timer        <= '0;
      trig_q       <= '0;
      period_o     <= 1'b0;
      period_cnt_o <= '0;
    end else begin
      timer        <= terminal_c ? '0 : timer + TW'(1);
      trig_q       <= trig_i;
      period_o     <= terminal_c;
      if (terminal_c) period_cnt_o <= period_cnt_o + 16'd1;
    end
  end

  // Saturating increment; the flag records an event that arrived while already at full scale
  always_comb begin
    sat_nxt = sat;
    for (int unsigned i = 0; i < NSCAL; i++) begin
      cnt_nxt[i] = cnt[i];
      if (count_en_i && event_c[i]) begin
        if (cnt[i] == CNT_MAX) sat_nxt[i] = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + SCAL_BITS'(1);
      end
    end
  end

  // Terminal cycle captures this cycle's update into the snapshot and restarts the live counts
  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sat <= '0;
      for (int unsigned i = 0; i < NSCAL; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
    end else if (terminal_c) begin
      sat <= '0;
      for (int unsigned i = 0; i < NSCAL; i++) begin
        cnt[i]  <= '0;
        snap[i] <= {sat_nxt[i], cnt_nxt[i]};
      end
    end else begin
      sat <= sat_nxt;
      for (int unsigned i = 0; i < NSCAL; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Readout sees the snapshot as it was before any same-cycle load
  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        if (32'(rd_addr_i) < NSCAL) rd_data_o <= snap[rd_addr_i];
        else                        rd_data_o <= '0;
      end
    end
  end

endmodule
